// File: rtl/avalon_burst_rd_master.sv
// Avalon-MM burst read master: splits a beat-count command into bursts of at most
// MAX_BURST beats, issuing each one only when the output FIFO has room for all of it.
module avalon_burst_rd_master #(
  parameter int unsigned DATA_W     = 1024,
  parameter int unsigned MAX_BURST  = 8,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                clk,
  input  logic                arst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [31:0]         cmd_addr,
  input  logic [15:0]         cmd_beats,
  output logic                done,
  output logic [31:0]         avm_address,
  output logic                avm_read,
  output logic [10:0]         avm_burstcount,
  output logic                avm_beginbursttransfer,
  output logic [DATA_W/8-1:0] avm_byteenable,
  input  logic                avm_waitrequest,
  input  logic [DATA_W-1:0]   avm_readdata,
  input  logic                avm_readdatavalid,
  output logic                out_valid,
  output logic [DATA_W-1:0]   out_data,
  input  logic                out_ready,
  output logic                err
);

  localparam int unsigned BYTES = DATA_W / 8;
  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  typedef enum logic [1:0] {IDLE, REQ, DATA} state_t;

  state_t      state, state_d;
  logic [31:0] addr, addr_d, iss_addr, address_d;
  logic [15:0] rem, rem_d, bs_src;
  logic [10:0] beat, beat_d, bs, bc_d;
  logic        read_d, begin_d, done_d, err_d, rdy_d;

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count, count_d, free;
  logic              push, pop, credit_ok;

  assign avm_byteenable = '1;
  assign out_data       = mem[rd_ptr];

  // Burst sizing and FIFO credit; in IDLE the candidate burst comes straight from the command
  always_comb begin
    bs_src    = (state == IDLE) ? cmd_beats : rem;
    bs        = (bs_src > 16'(MAX_BURST)) ? 11'(MAX_BURST) : 11'(bs_src);
    iss_addr  = (state == IDLE) ? cmd_addr : addr;
    pop       = out_valid && out_ready;
    push      = avm_readdatavalid && (state == DATA);
    free      = CNT_W'(FIFO_DEPTH) - count + CNT_W'(pop);
    credit_ok = 16'(free) >= 16'(bs);
    count_d   = count + CNT_W'(push) - CNT_W'(pop);
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d   = state;
    addr_d    = addr;
    rem_d     = rem;
    beat_d    = beat;
    read_d    = avm_read;
    begin_d   = 1'b0;
    address_d = avm_address;
    bc_d      = avm_burstcount;
    done_d    = 1'b0;
    err_d     = err;
    if (avm_readdatavalid && (state != DATA)) err_d = 1'b1;
    case (state)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          if (cmd_beats == 16'd0) begin
            done_d = 1'b1;
          end else begin
            state_d = REQ;
            addr_d  = cmd_addr;
            rem_d   = cmd_beats;
            if (credit_ok) begin
              read_d    = 1'b1;
              begin_d   = 1'b1;
              address_d = iss_addr;
              bc_d      = bs;
            end
          end
        end
      end
      REQ: begin
        if (!avm_read) begin
          if (credit_ok) begin
            read_d    = 1'b1;
            begin_d   = 1'b1;
            address_d = iss_addr;
            bc_d      = bs;
          end
        end else if (!avm_waitrequest) begin
          read_d  = 1'b0;
          beat_d  = 11'd0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (avm_readdatavalid) begin
          if (beat == avm_burstcount - 11'd1) begin
            beat_d = 11'd0;
            rem_d  = rem - 16'(avm_burstcount);
            addr_d = addr + 32'(avm_burstcount) * 32'(BYTES);
            if (rem == 16'(avm_burstcount)) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end else begin
              state_d = REQ;
            end
          end else begin
            beat_d = beat + 11'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    rdy_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state                  <= IDLE;
      addr                   <= '0;
      rem                    <= '0;
      beat                   <= '0;
      avm_read               <= 1'b0;
      avm_beginbursttransfer <= 1'b0;
      avm_address            <= '0;
      avm_burstcount         <= '0;
      done                   <= 1'b0;
      err                    <= 1'b0;
      cmd_ready              <= 1'b0;
    end else begin
      state                  <= state_d;
      addr                   <= addr_d;
      rem                    <= rem_d;
      beat                   <= beat_d;
      avm_read               <= read_d;
      avm_beginbursttransfer <= begin_d;
      avm_address            <= address_d;
      avm_burstcount         <= bc_d;
      done                   <= done_d;
      err                    <= err_d;
      cmd_ready              <= rdy_d;
    end
  end

  // Output FIFO pointers and occupancy
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      out_valid <= 1'b0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= (rd_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
      count     <= count_d;
      out_valid <= (count_d != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= avm_readdata;
  end

endmodule

// File: tb/tb_avalon_burst_rd_master.sv
// Directed bench for avalon_burst_rd_master with a behavioural Avalon burst slave
// and a monitor that records bursts, output beats and protocol violations.
module tb_avalon_burst_rd_master;

  localparam int unsigned DATA_W = 1024;

  logic              clk = 1'b0;
  logic              arst;
  logic              cmd_valid, cmd_ready, done, err;
  logic [31:0]       cmd_addr, avm_address;
  logic [15:0]       cmd_beats;
  logic              avm_read, avm_beginbursttransfer, avm_waitrequest, avm_readdatavalid;
  logic [10:0]       avm_burstcount;
  logic [DATA_W/8-1:0] avm_byteenable;
  logic [DATA_W-1:0] avm_readdata, out_data;
  logic              out_valid, out_ready;

  avalon_burst_rd_master #(.DATA_W(DATA_W), .MAX_BURST(8), .FIFO_DEPTH(16)) dut (
    .clk(clk), .arst(arst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_beats(cmd_beats),
    .done(done),
    .avm_address(avm_address), .avm_read(avm_read), .avm_burstcount(avm_burstcount),
    .avm_beginbursttransfer(avm_beginbursttransfer), .avm_byteenable(avm_byteenable),
    .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
    .avm_readdatavalid(avm_readdatavalid),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  // Monitor / slave state
  logic [31:0] baddr_q[$];
  int          bbc_q[$];
  logic [31:0] out_q[$];
  int begin_cnt = 0, read_cycles = 0, stable_viol = 0, hold_viol = 0;
  int done_cnt = 0, done_cyc = -1, rise_cyc = -1, beats_sent = 0, pend = 0;
  int stall_next = 0, stall_left = 0, inject_req = 0, inject_ack = 0;
  logic [31:0] word = 32'h100;
  int hs_cyc = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Slave responder and bus monitor, all on the falling edge
  initial begin : slave
    logic prev_stall, prev_read, hold_pend, acc;
    logic [31:0] p_addr;
    logic [10:0] p_bc;
    logic [DATA_W-1:0] held;
    prev_stall = 0; prev_read = 0; hold_pend = 0; p_addr = 0; p_bc = 0; held = '0;
    avm_waitrequest = 0; avm_readdatavalid = 0; avm_readdata = '0;
    forever begin
      @(negedge clk);
      if (out_valid && out_ready) out_q.push_back(out_data[31:0]);
      if (hold_pend && !(out_valid && out_data == held)) hold_viol++;
      hold_pend = out_valid && !out_ready;
      held = out_data;
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (avm_beginbursttransfer) begin
        begin_cnt++;
        stall_left = stall_next;
      end
      if (avm_read) read_cycles++;
      if (avm_read && !prev_read) rise_cyc = cyc;
      if (prev_stall && !(avm_read && avm_address == p_addr && avm_burstcount == p_bc))
        stable_viol++;
      avm_readdatavalid = 0;
      if (inject_req != inject_ack) begin
        inject_ack = inject_req;
        avm_readdatavalid = 1;
        avm_readdata = {(DATA_W/32){32'hDEAD_BEEF}};
      end else if (pend > 0) begin
        avm_readdatavalid = 1;
        avm_readdata = {(DATA_W/32){word}};
        word = word + 32'd1;
        pend--;
        beats_sent++;
      end
      acc = 0;
      if (avm_read && stall_left > 0) begin
        avm_waitrequest = 1;
        stall_left--;
      end else begin
        avm_waitrequest = 0;
        acc = avm_read;
      end
      prev_stall = avm_read && avm_waitrequest;
      prev_read = avm_read;
      p_addr = avm_address;
      p_bc = avm_burstcount;
      if (acc) begin
        baddr_q.push_back(avm_address);
        bbc_q.push_back(int'(avm_burstcount));
        pend += int'(avm_burstcount);
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic send_cmd(input logic [31:0] a, input logic [15:0] b);
    int n;
    n = 0;
    @(posedge clk); #1;
    cmd_valid = 1; cmd_addr = a; cmd_beats = b;
    do begin @(negedge clk); #1; n++; end while (!cmd_ready && n < 50);
    hs_cyc = cyc;
    chk("cmd_handshake", 64'(cmd_ready), 64'd1);
    @(posedge clk); #1;
    cmd_valid = 0;
  endtask

  task automatic wait_done(input int d0, input int budget, input string tag);
    int n;
    n = 0;
    while (done_cnt == d0 && n < budget) begin @(negedge clk); #1; n++; end
    chk({tag, "_done_seen"}, 64'(done_cnt > d0), 64'd1);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_cmd_ready"}, 64'(cmd_ready), 64'd0);
    chk({tag, "_avm_read"}, 64'(avm_read), 64'd0);
    chk({tag, "_begin"}, 64'(avm_beginbursttransfer), 64'd0);
    chk({tag, "_address"}, 64'(avm_address), 64'd0);
    chk({tag, "_burstcount"}, 64'(avm_burstcount), 64'd0);
    chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_err"}, 64'(err), 64'd0);
  endtask

  task automatic check_data(input string tag, input int o0, input int n, input logic [31:0] w0);
    chk({tag, "_nbeats"}, 64'(out_q.size() - o0), 64'(n));
    for (int i = 0; i < n && (o0 + i) < out_q.size(); i++)
      chk({tag, "_data"}, 64'(out_q[o0 + i]), 64'(w0 + 32'(i)));
  endtask

  initial begin : main
    int b0, o0, d0, g0, r0, s0, n;
    logic [31:0] w0;
    arst = 1; cmd_valid = 0; cmd_addr = 0; cmd_beats = 0; out_ready = 1;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    check_reset("rst0");
    chk("rst0_byteenable", 64'(avm_byteenable == '1), 64'd1);
    @(posedge clk); #1 arst = 0;
    repeat (2) @(negedge clk); #1;
    chk("rst0_cmd_ready_after", 64'(cmd_ready), 64'd1);

    // 20 beats from 0x1000 split into 8/8/4
    b0 = baddr_q.size(); o0 = out_q.size(); d0 = done_cnt; g0 = begin_cnt; w0 = word;
    send_cmd(32'h1000, 16'd20);
    wait_done(d0, 400, "t20");
    repeat (4) @(negedge clk); #1;
    chk("t20_nbursts", 64'(baddr_q.size() - b0), 64'd3);
    chk("t20_addr0", 64'(baddr_q[b0]), 64'h1000);
    chk("t20_bc0", 64'(bbc_q[b0]), 64'd8);
    chk("t20_addr1", 64'(baddr_q[b0 + 1]), 64'h1400);
    chk("t20_bc1", 64'(bbc_q[b0 + 1]), 64'd8);
    chk("t20_addr2", 64'(baddr_q[b0 + 2]), 64'h1800);
    chk("t20_bc2", 64'(bbc_q[b0 + 2]), 64'd4);
    check_data("t20", o0, 20, w0);
    chk("t20_done_once", 64'(done_cnt - d0), 64'd1);
    chk("t20_begin_cnt", 64'(begin_cnt - g0), 64'd3);
    chk("t20_read_latency", 64'(rise_cyc > hs_cyc), 64'd1);

    // zero-beat command
    r0 = read_cycles; d0 = done_cnt;
    send_cmd(32'h7000, 16'd0);
    wait_done(d0, 10, "t0");
    chk("t0_done_cycle", 64'(done_cyc), 64'(hs_cyc + 1));
    repeat (5) @(negedge clk); #1;
    chk("t0_no_read", 64'(read_cycles - r0), 64'd0);
    chk("t0_done_once", 64'(done_cnt - d0), 64'd1);

    // waitrequest held for five cycles on the first request
    b0 = baddr_q.size(); o0 = out_q.size(); d0 = done_cnt; g0 = begin_cnt; r0 = read_cycles;
    w0 = word; stall_next = 5;
    send_cmd(32'h3000, 16'd8);
    wait_done(d0, 200, "tws");
    stall_next = 0;
    repeat (4) @(negedge clk); #1;
    chk("tws_read_cycles", 64'(read_cycles - r0), 64'd6);
    chk("tws_begin_cnt", 64'(begin_cnt - g0), 64'd1);
    chk("tws_stable", 64'(stable_viol), 64'd0);
    chk("tws_addr", 64'(baddr_q[b0]), 64'h3000);
    chk("tws_bc", 64'(bbc_q[b0]), 64'd8);
    check_data("tws", o0, 8, w0);

    // backpressure: FIFO fills to 16 then the master stalls
    b0 = baddr_q.size(); o0 = out_q.size(); d0 = done_cnt; w0 = word;
    @(posedge clk); #1 out_ready = 0;
    send_cmd(32'h4000, 16'd40);
    repeat (60) @(negedge clk); #1;
    chk("tbp_stall_bursts", 64'(baddr_q.size() - b0), 64'd2);
    chk("tbp_stall_nopop", 64'(out_q.size() - o0), 64'd0);
    chk("tbp_stall_valid", 64'(out_valid), 64'd1);
    chk("tbp_stall_read", 64'(avm_read), 64'd0);
    chk("tbp_stall_nodone", 64'(done_cnt - d0), 64'd0);
    @(posedge clk); #1 out_ready = 1;
    wait_done(d0, 800, "tbp");
    repeat (4) @(negedge clk); #1;
    chk("tbp_nbursts", 64'(baddr_q.size() - b0), 64'd5);
    for (int i = 0; i < 5 && (b0 + i) < baddr_q.size(); i++) begin
      chk("tbp_addr", 64'(baddr_q[b0 + i]), 64'(32'h4000 + 32'(i) * 32'h400));
      chk("tbp_bc", 64'(bbc_q[b0 + i]), 64'd8);
    end
    check_data("tbp", o0, 40, w0);
    chk("tbp_hold", 64'(hold_viol), 64'd0);

    // stray readdatavalid while idle
    chk("tstray_err_before", 64'(err), 64'd0);
    @(posedge clk); #1 inject_req++;
    repeat (3) @(negedge clk); #1;
    chk("tstray_err", 64'(err), 64'd1);
    chk("tstray_fifo", 64'(out_valid), 64'd0);
    repeat (3) @(negedge clk); #1;
    chk("tstray_sticky", 64'(err), 64'd1);

    // reset in the middle of a burst after three beats
    s0 = beats_sent; n = 0;
    send_cmd(32'h5000, 16'd8);
    while (beats_sent < s0 + 3 && n < 100) begin @(negedge clk); #1; n++; end
    chk("trst_three_beats", 64'(beats_sent - s0), 64'd3);
    @(posedge clk); #1 arst = 1;
    @(negedge clk); #1;
    check_reset("trst");
    @(posedge clk); #1;
    @(posedge clk); #1 arst = 0;
    n = 0;
    while (pend > 0 && n < 50) begin @(negedge clk); #1; n++; end
    repeat (2) @(negedge clk); #1;
    chk("trst_stray_err", 64'(err), 64'd1);
    chk("trst_fifo_empty", 64'(out_valid), 64'd0);
    chk("trst_cmd_ready", 64'(cmd_ready), 64'd1);
    b0 = baddr_q.size(); o0 = out_q.size(); d0 = done_cnt; w0 = word;
    send_cmd(32'h2000, 16'd8);
    wait_done(d0, 200, "tpost");
    repeat (4) @(negedge clk); #1;
    chk("tpost_nbursts", 64'(baddr_q.size() - b0), 64'd1);
    chk("tpost_addr", 64'(baddr_q[b0]), 64'h2000);
    chk("tpost_bc", 64'(bbc_q[b0]), 64'd8);
    check_data("tpost", o0, 8, w0);
    chk("tpost_done_once", 64'(done_cnt - d0), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
